// File: rtl/srt_link.sv
`timescale 1ns/1ps
// srt_link: single-clock serial link, transmitter plus mid-bit-sampling receiver.
// Frame: start(0), data MSB first, optional even parity, stop(1); BIT_CYC cycles/bit.
// Define SRT_PARITY_EN to compile in the parity bit (TX generate, RX check).
module srt_link #(
   parameter int DATA_W  = 8,
   parameter int BIT_CYC = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              send,
   input  logic [DATA_W-1:0] d,
   output logic              busy,
   output logic              tx,
   input  logic              rx,
   input  logic              en,
   output logic [DATA_W-1:0] q,
   output logic              q_valid,
   input  logic              q_ack,
   output logic              err,
   output logic [1:0]        err_type
);

   localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
   localparam int BW = $clog2(DATA_W + 1);
   localparam logic [CW-1:0] HALF_C  = CW'(BIT_CYC / 2);
   localparam logic [CW-1:0] LAST_C  = CW'(BIT_CYC - 1);
   localparam logic [BW-1:0] BLAST_C = BW'(DATA_W - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef SRT_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

`ifdef SRT_PARITY_EN
   localparam state_t AFTER_DATA = PARITY;
`else
   localparam state_t AFTER_DATA = STOP;
`endif
   // With one cycle per bit the detect cycle already is the start sample.
   localparam state_t        DET_STATE = (BIT_CYC == 1) ? DATA : START;
   localparam logic [CW-1:0] DET_CYC   = (BIT_CYC == 1) ? '0 : CW'(1);

   // ---------------- transmitter ----------------
   state_t              tx_state_reg, tx_state_next;
   logic [CW-1:0]       tx_cyc_reg;
   logic [BW-1:0]       tx_bit_reg;
   logic [DATA_W-1:0]   tx_sh_reg;
   logic                tx_par_reg;
   logic                tx_end;
   logic                tx_line;

   assign tx_end = (tx_cyc_reg == LAST_C);
   assign busy   = (tx_state_reg != IDLE);
   assign tx     = tx_line;

   // TX state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) tx_state_reg <= IDLE;
      else     tx_state_reg <= tx_state_next;
   end

   // TX next state and line level, derived from state so reset forces idle-high at once
   always_comb begin
      tx_state_next = tx_state_reg;
      tx_line       = 1'b1;
      case (tx_state_reg)
         IDLE:   if (send) tx_state_next = START;
         START: begin
            tx_line = 1'b0;
            if (tx_end) tx_state_next = DATA;
         end
         DATA: begin
            tx_line = tx_sh_reg[DATA_W-1];
            if (tx_end && tx_bit_reg == BLAST_C) tx_state_next = AFTER_DATA;
         end
`ifdef SRT_PARITY_EN
         PARITY: begin
            tx_line = tx_par_reg;
            if (tx_end) tx_state_next = STOP;
         end
`endif
         STOP:   if (tx_end) tx_state_next = IDLE;
         default: tx_state_next = IDLE;
      endcase
   end

   // TX word capture, bit/cycle counters and shift register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_cyc_reg <= '0;
         tx_bit_reg <= '0;
         tx_sh_reg  <= '0;
         tx_par_reg <= 1'b0;
      end else if (tx_state_reg == IDLE) begin
         tx_cyc_reg <= '0;
         tx_bit_reg <= '0;
         if (send) begin
            tx_sh_reg  <= d;
            tx_par_reg <= ^d;
         end
      end else begin
         tx_cyc_reg <= tx_end ? '0 : tx_cyc_reg + 1'b1;
         if (tx_state_reg == DATA && tx_end) begin
            tx_bit_reg <= tx_bit_reg + 1'b1;
            tx_sh_reg  <= tx_sh_reg << 1;
         end
      end
   end

   // ---------------- receiver ----------------
   state_t              rx_state_reg, rx_state_next;
   logic [CW-1:0]       rx_cyc_reg, rx_cyc_next;
   logic [BW-1:0]       rx_bit_reg, rx_bit_next;
   logic [DATA_W-1:0]   rx_sh_reg, rx_sh_next;
   logic                rx_par_reg, rx_par_next;
   logic [DATA_W-1:0]   q_reg, q_next;
   logic                q_valid_reg, q_valid_next;
   logic                err_reg, err_next;
   logic [1:0]          err_type_reg, err_type_next;
   logic                rx_sample, rx_end, par_bad;

   assign rx_sample = (rx_cyc_reg == HALF_C);
   assign rx_end    = (rx_cyc_reg == LAST_C);
`ifdef SRT_PARITY_EN
   assign par_bad   = (^rx_sh_reg) != rx_par_reg;
`else
   assign par_bad   = 1'b0;
`endif

   assign q        = q_reg;
   assign q_valid  = q_valid_reg;
   assign err      = err_reg;
   assign err_type = err_type_reg;

   // RX registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state_reg <= IDLE;
         rx_cyc_reg   <= '0;
         rx_bit_reg   <= '0;
         rx_sh_reg    <= '0;
         rx_par_reg   <= 1'b0;
         q_reg        <= '0;
         q_valid_reg  <= 1'b0;
         err_reg      <= 1'b0;
         err_type_reg <= 2'b00;
      end else begin
         rx_state_reg <= rx_state_next;
         rx_cyc_reg   <= rx_cyc_next;
         rx_bit_reg   <= rx_bit_next;
         rx_sh_reg    <= rx_sh_next;
         rx_par_reg   <= rx_par_next;
         q_reg        <= q_next;
         q_valid_reg  <= q_valid_next;
         err_reg      <= err_next;
         err_type_reg <= err_type_next;
      end
   end

   // RX next state: mid-bit sampling, frame result decided at the stop sample
   always_comb begin
      rx_state_next = rx_state_reg;
      rx_cyc_next   = rx_cyc_reg;
      rx_bit_next   = rx_bit_reg;
      rx_sh_next    = rx_sh_reg;
      rx_par_next   = rx_par_reg;
      q_next        = q_reg;
      q_valid_next  = q_valid_reg & ~q_ack;
      err_next      = 1'b0;
      err_type_next = err_type_reg;
      if (!en) begin
         rx_state_next = IDLE;
         rx_cyc_next   = '0;
         rx_bit_next   = '0;
      end else begin
         case (rx_state_reg)
            IDLE: begin
               rx_cyc_next = '0;
               rx_bit_next = '0;
               if (!rx) begin
                  rx_state_next = DET_STATE;
                  rx_cyc_next   = DET_CYC;
               end
            end
            START: begin
               if (rx_sample && rx) begin
                  rx_state_next = IDLE;
                  rx_cyc_next   = '0;
               end else if (rx_end) begin
                  rx_state_next = DATA;
                  rx_cyc_next   = '0;
               end else begin
                  rx_cyc_next = rx_cyc_reg + 1'b1;
               end
            end
            DATA: begin
               if (rx_sample) rx_sh_next = (rx_sh_reg << 1) | DATA_W'(rx);
               if (rx_end) begin
                  rx_cyc_next = '0;
                  rx_bit_next = rx_bit_reg + 1'b1;
                  if (rx_bit_reg == BLAST_C) rx_state_next = AFTER_DATA;
               end else begin
                  rx_cyc_next = rx_cyc_reg + 1'b1;
               end
            end
`ifdef SRT_PARITY_EN
            PARITY: begin
               if (rx_sample) rx_par_next = rx;
               if (rx_end) begin
                  rx_cyc_next   = '0;
                  rx_state_next = STOP;
               end else begin
                  rx_cyc_next = rx_cyc_reg + 1'b1;
               end
            end
`endif
            STOP: begin
               if (rx_sample) begin
                  rx_state_next = IDLE;
                  rx_cyc_next   = '0;
                  if (!rx) begin
                     err_next      = 1'b1;
                     err_type_next = 2'b01;
                  end else if (par_bad) begin
                     err_next      = 1'b1;
                     err_type_next = 2'b10;
                  end else if (q_valid_reg && !q_ack) begin
                     err_next      = 1'b1;
                     err_type_next = 2'b11;
                  end else begin
                     q_next        = rx_sh_reg;
                     q_valid_next  = 1'b1;
                     err_type_next = 2'b00;
                  end
               end else begin
                  rx_cyc_next = rx_cyc_reg + 1'b1;
               end
            end
            default: begin
               rx_state_next = IDLE;
               rx_cyc_next   = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_srt_link.sv
`timescale 1ns/1ps
// tb_srt_link: directed self-checking bench for srt_link (DATA_W=8, BIT_CYC=4),
// plus a second instance with BIT_CYC=1 in loopback.
module tb_srt_link;

   localparam int DW = 8;
   localparam int BC = 4;
`ifdef SRT_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int FRAME_CYC = (2 + DW + P) * BC;
   localparam int QV_IDX    = (1 + DW + P) * BC + BC / 2 + 1;
   localparam int FRAME1    = 2 + DW + P;
   localparam int QV1       = (1 + DW + P) + 1;

   logic          clk = 1'b0;
   logic          rst, send, en, q_ack, loop, rx_drv;
   logic [DW-1:0] d, q;
   logic          busy, tx, rx, q_valid, err;
   logic [1:0]    err_type;

   logic          send1, q_ack1;
   logic [DW-1:0] d1, q1;
   logic          busy1, tx1, q_valid1, err1;
   logic [1:0]    err_type1;

   int tests = 0;
   int fails = 0;

   assign rx = loop ? tx : rx_drv;

   srt_link #(.DATA_W(DW), .BIT_CYC(BC)) dut (
      .clk(clk), .rst(rst), .send(send), .d(d), .busy(busy), .tx(tx),
      .rx(rx), .en(en), .q(q), .q_valid(q_valid), .q_ack(q_ack),
      .err(err), .err_type(err_type)
   );

   srt_link #(.DATA_W(DW), .BIT_CYC(1)) dut1 (
      .clk(clk), .rst(rst), .send(send1), .d(d1), .busy(busy1), .tx(tx1),
      .rx(tx1), .en(en), .q(q1), .q_valid(q_valid1), .q_ack(q_ack1),
      .err(err1), .err_type(err_type1)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic ack;
      q_ack = 1'b1;
      step();
      q_ack = 1'b0;
   endtask

   // Send one word over the loopback and observe the whole frame.
   task automatic run_frame(input logic [DW-1:0] val, output int bcnt,
                            output int qidx, output int ecnt);
      d = val; send = 1'b1;
      step();
      send = 1'b0;
      bcnt = 0; qidx = -1; ecnt = 0;
      for (int i = 0; i < FRAME_CYC + 16; i++) begin
         if (busy) bcnt++;
         if (q_valid && qidx < 0) qidx = i;
         if (err) ecnt++;
         step();
      end
      $display("[TB] frame d=%h busy=%0d qvalid_at=%0d errs=%0d q=%h type=%b",
               val, bcnt, qidx, ecnt, q, err_type);
   endtask

   // Drive a hand-built frame on rx and count err pulses.
   task automatic drive_frame(input logic [DW-1:0] val, input logic par,
                              input logic stop, output int ecnt);
      logic bits[$];
      loop = 1'b0;
      ecnt = 0;
      bits.push_back(1'b0);
      for (int i = DW - 1; i >= 0; i--) bits.push_back(val[i]);
      if (P == 1) bits.push_back(par);
      bits.push_back(stop);
      foreach (bits[k]) begin
         rx_drv = bits[k];
         for (int c = 0; c < BC; c++) begin
            step();
            if (err) ecnt++;
         end
      end
      rx_drv = 1'b1;
      for (int c = 0; c < 12; c++) begin
         step();
         if (err) ecnt++;
      end
      $display("[TB] driven d=%h par=%b stop=%b errs=%0d type=%b q=%h",
               val, par, stop, ecnt, err_type, q);
   endtask

   task automatic test_reset;
      rst = 1'b1; send = 1'b0; d = '0; en = 1'b1; q_ack = 1'b0;
      loop = 1'b1; rx_drv = 1'b1; send1 = 1'b0; d1 = '0; q_ack1 = 1'b0;
      step(); step(); step();
      tests++; if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b want 1", tx); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
      tests++; if (q !== 8'h00) begin fails++; $display("FAIL reset_q: got %h want 00", q); end
      tests++; if (q_valid !== 1'b0) begin fails++; $display("FAIL reset_qvalid: got %b want 0", q_valid); end
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err); end
      tests++; if (err_type !== 2'b00) begin fails++; $display("FAIL reset_errtype: got %b want 00", err_type); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_send;
      int bcnt, qidx, ecnt;
      run_frame(8'hA5, bcnt, qidx, ecnt);
      tests++; if (bcnt != FRAME_CYC) begin fails++; $display("FAIL send_busylen: got %0d want %0d", bcnt, FRAME_CYC); end
      tests++; if (qidx != QV_IDX) begin fails++; $display("FAIL send_qvalid_time: got %0d want %0d", qidx, QV_IDX); end
      tests++; if (q !== 8'hA5) begin fails++; $display("FAIL send_q: got %h want a5", q); end
      tests++; if (ecnt != 0) begin fails++; $display("FAIL send_err: got %0d want 0", ecnt); end
      tests++; if (err_type !== 2'b00) begin fails++; $display("FAIL send_errtype: got %b want 00", err_type); end
      ack();
      tests++; if (q_valid !== 1'b0) begin fails++; $display("FAIL send_ack_clear: got %b want 0", q_valid); end
      tests++; if (q !== 8'hA5) begin fails++; $display("FAIL send_q_kept: got %h want a5", q); end
   endtask

   task automatic test_framing;
      int ecnt;
      drive_frame(8'h5A, 1'b0, 1'b0, ecnt);
      tests++; if (ecnt != 1) begin fails++; $display("FAIL framing_pulses: got %0d want 1", ecnt); end
      tests++; if (err_type !== 2'b01) begin fails++; $display("FAIL framing_type: got %b want 01", err_type); end
      tests++; if (q_valid !== 1'b0) begin fails++; $display("FAIL framing_qvalid: got %b want 0", q_valid); end
      tests++; if (q !== 8'hA5) begin fails++; $display("FAIL framing_q: got %h want a5", q); end
      loop = 1'b1;
   endtask

`ifdef SRT_PARITY_EN
   task automatic test_parity;
      int ecnt;
      drive_frame(8'h01, 1'b0, 1'b1, ecnt);
      tests++; if (ecnt != 1) begin fails++; $display("FAIL parity_pulses: got %0d want 1", ecnt); end
      tests++; if (err_type !== 2'b10) begin fails++; $display("FAIL parity_type: got %b want 10", err_type); end
      tests++; if (q !== 8'hA5) begin fails++; $display("FAIL parity_q: got %h want a5", q); end
      tests++; if (q_valid !== 1'b0) begin fails++; $display("FAIL parity_qvalid: got %b want 0", q_valid); end
      loop = 1'b1;
   endtask
`endif

   task automatic test_overrun;
      int bcnt, qidx, ecnt;
      run_frame(8'h3C, bcnt, qidx, ecnt);
      tests++; if (q !== 8'h3C) begin fails++; $display("FAIL overrun_first_q: got %h want 3c", q); end
      tests++; if (ecnt != 0) begin fails++; $display("FAIL overrun_first_err: got %0d want 0", ecnt); end
      tests++; if (err_type !== 2'b00) begin fails++; $display("FAIL overrun_first_type: got %b want 00", err_type); end
      run_frame(8'hC3, bcnt, qidx, ecnt);
      tests++; if (ecnt != 1) begin fails++; $display("FAIL overrun_pulses: got %0d want 1", ecnt); end
      tests++; if (err_type !== 2'b11) begin fails++; $display("FAIL overrun_type: got %b want 11", err_type); end
      tests++; if (q !== 8'h3C) begin fails++; $display("FAIL overrun_q: got %h want 3c", q); end
      tests++; if (q_valid !== 1'b1) begin fails++; $display("FAIL overrun_qvalid: got %b want 1", q_valid); end
      ack();
   endtask

   task automatic test_busy_ignore;
      int bcnt;
      d = 8'h81; send = 1'b1;
      step();
      d = 8'hFF;
      bcnt = 0;
      for (int i = 0; i < FRAME_CYC + 16; i++) begin
         if (busy) bcnt++;
         if (i == 10) send = 1'b0;
         step();
      end
      $display("[TB] busy-ignore frame busy=%0d q=%h", bcnt, q);
      tests++; if (bcnt != FRAME_CYC) begin fails++; $display("FAIL ignore_busylen: got %0d want %0d", bcnt, FRAME_CYC); end
      tests++; if (q !== 8'h81) begin fails++; $display("FAIL ignore_q: got %h want 81", q); end
      ack();
   endtask

   task automatic test_reset_mid;
      int bcnt, qidx, ecnt;
      d = 8'hA5; send = 1'b1;
      step();
      send = 1'b0;
      for (int i = 0; i < 17; i++) step();
      tests++; if (tx !== 1'b0) begin fails++; $display("FAIL midrst_pre_tx: got %b want 0", tx); end
      rst = 1'b1;
      #1;
      tests++; if (tx !== 1'b1) begin fails++; $display("FAIL midrst_tx: got %b want 1", tx); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b want 0", busy); end
      step();
      rst = 1'b0;
      step();
      run_frame(8'h0F, bcnt, qidx, ecnt);
      tests++; if (q !== 8'h0F) begin fails++; $display("FAIL midrst_q: got %h want 0f", q); end
      tests++; if (ecnt != 0) begin fails++; $display("FAIL midrst_err: got %0d want 0", ecnt); end
      tests++; if (qidx != QV_IDX) begin fails++; $display("FAIL midrst_qvalid_time: got %0d want %0d", qidx, QV_IDX); end
      ack();
   endtask

   task automatic test_glitch;
      int bcnt, qidx, ecnt, qv_seen, err_seen;
      loop = 1'b0; rx_drv = 1'b1;
      step();
      rx_drv = 1'b0;
      step();
      rx_drv = 1'b1;
      qv_seen = 0; err_seen = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (q_valid) qv_seen++;
         if (err) err_seen++;
      end
      $display("[TB] glitch qvalid_cycles=%0d err_cycles=%0d", qv_seen, err_seen);
      tests++; if (qv_seen != 0) begin fails++; $display("FAIL glitch_qvalid: got %0d want 0", qv_seen); end
      tests++; if (err_seen != 0) begin fails++; $display("FAIL glitch_err: got %0d want 0", err_seen); end
      loop = 1'b1;
      run_frame(8'h55, bcnt, qidx, ecnt);
      tests++; if (q !== 8'h55) begin fails++; $display("FAIL glitch_next_q: got %h want 55", q); end
      tests++; if (ecnt != 0) begin fails++; $display("FAIL glitch_next_err: got %0d want 0", ecnt); end
      tests++; if (qidx != QV_IDX) begin fails++; $display("FAIL glitch_next_time: got %0d want %0d", qidx, QV_IDX); end
      ack();
   endtask

   task automatic test_bitcyc1;
      int bcnt, qidx, ecnt;
      d1 = 8'h96; send1 = 1'b1;
      step();
      send1 = 1'b0;
      bcnt = 0; qidx = -1; ecnt = 0;
      for (int i = 0; i < FRAME1 + 10; i++) begin
         if (busy1) bcnt++;
         if (q_valid1 && qidx < 0) qidx = i;
         if (err1) ecnt++;
         step();
      end
      $display("[TB] bitcyc1 frame d=96 busy=%0d qvalid_at=%0d errs=%0d q=%h", bcnt, qidx, ecnt, q1);
      tests++; if (bcnt != FRAME1) begin fails++; $display("FAIL bc1_busylen: got %0d want %0d", bcnt, FRAME1); end
      tests++; if (qidx != QV1) begin fails++; $display("FAIL bc1_qvalid_time: got %0d want %0d", qidx, QV1); end
      tests++; if (q1 !== 8'h96) begin fails++; $display("FAIL bc1_q: got %h want 96", q1); end
      tests++; if (ecnt != 0) begin fails++; $display("FAIL bc1_err: got %0d want 0", ecnt); end
   endtask

   initial begin
      test_reset();
      test_send();
      test_framing();
`ifdef SRT_PARITY_EN
      test_parity();
`endif
      test_overrun();
      test_busy_ignore();
      test_reset_mid();
      test_glitch();
      test_bitcyc1();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/srt_link.md
# srt_link

Parametrised single-clock serial link: a transmitter that serialises a DATA_W-bit word into a start/data/parity/stop frame, and a receiver that deserialises it with mid-bit sampling, error detection and a valid/ack output handshake. It replaces the fixed 8-bit transmit/receive pair and its external ack generators at the serial-system top level. Configurable bit period. TX and RX lines are separate ports; loopback means tying tx to rx externally.

## Interface
- DATA_W, 8, data word width (≥1)
- BIT_CYC, 4, clock cycles per serial bit (≥1)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- send  in  1  transmit request, sampled only when busy=0
- d  in  DATA_W  word to transmit, captured with send
- busy  out  1  transmitter frame in progress
- tx  out  1  serial line out, idle high
- rx  in  1  serial line in, synchronous to clk (no synchroniser)
- en  in  1  receiver enable
- q  out  DATA_W  last accepted received word
- q_valid  out  1  q holds unconsumed data
- q_ack  in  1  consumer accepts q
- err  out  1  one-cycle pulse on a receive error
- err_type  out  2  00 ok, 01 framing, 10 parity, 11 overrun; held until next frame result

## Operation
- Frame: start (0), data bits d[DATA_W-1] down to d[0] (MSB first), optional even-parity bit (XOR of data), stop (1). Each bit lasts exactly BIT_CYC cycles.
- TX FSM: IDLE → START → DATA → [PARITY] → STOP → IDLE. A bit counter counts DATA_W bits; a cycle counter counts BIT_CYC.
- In IDLE, send=1 latches d. START begins the next cycle. send while busy=1 is ignored; d is not re-sampled during a frame.
- busy is high in every non-IDLE TX state. Total busy length is (2+DATA_W+P)·BIT_CYC cycles, where P=1 if parity is compiled in, else 0. STOP returns to IDLE, and a new send is accepted in the first IDLE cycle.
- RX FSM: IDLE → START → DATA → [PARITY] → STOP → IDLE.
- In IDLE with en=1, the first cycle with rx=0 is detect cycle 0.
- Bit k (k=0 is start) is sampled at offset k·BIT_CYC + BIT_CYC/2 (integer division) from detect.
- Start sample =1: false start, return to IDLE, no flags.
- Stop sample =0: framing error, err pulse, err_type=01, q/q_valid unchanged.
- Parity mismatch (checked at the stop sample, framing takes priority): err_type=10, frame dropped.
- Good frame while q_valid=1 and q_ack=0: overrun, err_type=11, new word dropped, q kept.
- Good frame otherwise: q loaded, q_valid=1, err_type=00, err=0.
- RX returns to IDLE on the cycle after the stop sample and can detect a new start immediately.
- en=0 forces RX to IDLE, aborting any frame without flags. q, q_valid and err_type are retained.
- q_valid stays high until q_ack=1 is sampled, then clears next cycle. q_ack with q_valid=0 has no effect.
- Good frame completing in the same cycle as q_ack with q_valid=1: new word is loaded, q_valid stays 1, no overrun.

## Timing
- Reset values: tx=1, busy=0, q=0, q_valid=0, err=0, err_type=00; both FSMs in IDLE; counters 0.
- Reset mid-frame aborts both FSMs immediately: tx goes high asynchronously and the partial frame is lost.
- send at cycle n: busy=1 and tx=0 from cycle n+1.
- Stop sample at detect offset (1+DATA_W+P)·BIT_CYC + BIT_CYC/2. q/q_valid/err/err_type update one cycle after it (registered).
- BIT_CYC=1: every bit is sampled at offset 0 of its bit period. This must work.

## Configuration
- SRT_PARITY_EN defined:
  - PARITY state present in both FSMs (P=1).
  - Transmitter sends an even-parity bit; receiver checks it and reports err_type=10 on mismatch.
- SRT_PARITY_EN undefined:
  - No PARITY state (P=1 becomes P=0); frame is start/data/stop only.
  - err_type=10 never occurs.

## Test plan
All cases use DATA_W=8, BIT_CYC=4, tx looped to rx, en=1 unless stated.
- Send d=8'hA5: busy high 44 cycles (40 without parity); q=8'hA5 and q_valid=1 one cycle after the stop sample; err stays 0. q_ack clears q_valid the next cycle.
- Bench drives rx with a frame whose stop bit is 0: err pulses once, err_type=01, q_valid stays 0.
- SRT_PARITY_EN defined; bench drives 8'h01 with parity bit 0: err pulses, err_type=10, q unchanged.
- Send 8'h3C, then 8'hC3, with no q_ack: q=8'h3C, q_valid=1, err pulse with err_type=11 after the second frame.
- Assert rst during data bit 3 of a frame: tx=1 and busy=0 immediately. After release, send 8'h0F: received q=8'h0F with no error.
- One-cycle low glitch on an idle rx: no q_valid, no err, RX back in IDLE. A following real frame 8'h55 is received correctly.
